// File: rtl/mem_stage.sv
// Memory pipeline stage: issues one data-memory access at a time, stalls upstream until
// ack or timeout, and registers the MEM/WB result plus one-cycle fault pulses.
module mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] result_EXMEM,
    input  logic [31:0] writeData_EXMEM,
    input  logic [4:0]  rd_EXMEM,
    input  logic        regWrite_EXMEM,
    input  logic        memRead_EXMEM,
    input  logic        memWrite_EXMEM,
    input  logic        memToReg_EXMEM,
    input  logic        valid_EXMEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [4:0]  rd_MEMWB,
    output logic        regWrite_MEMWB,
    output logic [31:0] valueToWB,
    output logic        misaligned,
    output logic        busError
);

    typedef enum logic {StIdle, StAccess} state_e;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [4:0]  rd_q, rd_d;
    logic        rw_q, rw_d;
    logic        m2r_q, m2r_d;

    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_rw_q, wb_rw_d;
    logic [31:0] wb_val_q, wb_val_d;
    logic        mis_q, mis_d;
    logic        berr_q, berr_d;

    logic        mem_op;
    logic        aligned;
    logic        timeout_hit;
    logic        stall_c;

    assign mem_op      = valid_EXMEM & (memRead_EXMEM | memWrite_EXMEM);
    assign aligned     = (result_EXMEM[1:0] == 2'b00);
    assign timeout_hit = (cnt_q == CntLast);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        rd_d     = rd_q;
        rw_d     = rw_q;
        m2r_d    = m2r_q;
        wb_rd_d  = wb_rd_q;
        wb_rw_d  = 1'b0;
        wb_val_d = wb_val_q;
        mis_d    = 1'b0;
        berr_d   = 1'b0;
        stall_c  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (mem_op && aligned) begin
                    stall_c = 1'b1;
                    state_d = StAccess;
                    cnt_d   = 8'd0;
                    addr_d  = result_EXMEM;
                    wdata_d = writeData_EXMEM;
                    we_d    = memWrite_EXMEM;
                    rd_d    = rd_EXMEM;
                    rw_d    = regWrite_EXMEM;
                    m2r_d   = memToReg_EXMEM;
                end else if (mem_op) begin
                    mis_d = 1'b1;
                end else begin
                    wb_rd_d  = rd_EXMEM;
                    wb_rw_d  = regWrite_EXMEM & valid_EXMEM;
                    wb_val_d = result_EXMEM;
                end
            end
            StAccess: begin
                // Ack takes priority over an expiring timeout.
                if (dmem_ack) begin
                    state_d  = StIdle;
                    wb_rd_d  = rd_q;
                    wb_rw_d  = rw_q & ~we_q;
                    wb_val_d = m2r_q ? dmem_rdata : addr_q;
                end else if (timeout_hit) begin
                    state_d = StIdle;
                    berr_d  = 1'b1;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            we_q     <= 1'b0;
            rd_q     <= 5'd0;
            rw_q     <= 1'b0;
            m2r_q    <= 1'b0;
            wb_rd_q  <= 5'd0;
            wb_rw_q  <= 1'b0;
            wb_val_q <= 32'd0;
            mis_q    <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            rd_q     <= rd_d;
            rw_q     <= rw_d;
            m2r_q    <= m2r_d;
            wb_rd_q  <= wb_rd_d;
            wb_rw_q  <= wb_rw_d;
            wb_val_q <= wb_val_d;
            mis_q    <= mis_d;
            berr_q   <= berr_d;
        end
    end

    // Request port is zeroed whenever no access is outstanding.
    assign dmem_req   = (state_q == StAccess);
    assign dmem_we    = dmem_req & we_q;
    assign dmem_addr  = dmem_req ? addr_q : 32'd0;
    assign dmem_wdata = dmem_req ? wdata_q : 32'd0;

    assign stall          = stall_c & reset;
    assign rd_MEMWB       = wb_rd_q;
    assign regWrite_MEMWB = wb_rw_q;
    assign valueToWB      = wb_val_q;
    assign misaligned     = mis_q;
    assign busError       = berr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected events, a negedge monitor
// pops and compares every request, writeback and fault pulse the DUT presents.
module tb_mem_stage;

    localparam logic [1:0] KReq = 2'd0;
    localparam logic [1:0] KWb  = 2'd1;
    localparam logic [1:0] KMis = 2'd2;
    localparam logic [1:0] KBus = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    logic        clk;
    logic        reset;
    logic [31:0] result_EXMEM;
    logic [31:0] writeData_EXMEM;
    logic [4:0]  rd_EXMEM;
    logic        regWrite_EXMEM;
    logic        memRead_EXMEM;
    logic        memWrite_EXMEM;
    logic        memToReg_EXMEM;
    logic        valid_EXMEM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [4:0]  rd_MEMWB;
    logic        regWrite_MEMWB;
    logic [31:0] valueToWB;
    logic        misaligned;
    logic        busError;

    int   n_vec = 0;
    int   n_err = 0;
    ev_t  exp_q[$];
    logic req_prev;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .result_EXMEM    (result_EXMEM),
        .writeData_EXMEM (writeData_EXMEM),
        .rd_EXMEM        (rd_EXMEM),
        .regWrite_EXMEM  (regWrite_EXMEM),
        .memRead_EXMEM   (memRead_EXMEM),
        .memWrite_EXMEM  (memWrite_EXMEM),
        .memToReg_EXMEM  (memToReg_EXMEM),
        .valid_EXMEM     (valid_EXMEM),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_ack        (dmem_ack),
        .dmem_rdata      (dmem_rdata),
        .stall           (stall),
        .rd_MEMWB        (rd_MEMWB),
        .regWrite_MEMWB  (regWrite_MEMWB),
        .valueToWB       (valueToWB),
        .misaligned      (misaligned),
        .busError        (busError)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [4:0] rd, input logic we,
                        input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        e.kind = kind;
        e.rd   = rd;
        e.we   = we;
        e.a    = a;
        e.b    = b;
        exp_q.push_back(e);
    endtask

    task automatic take(input logic [1:0] kind, input logic [4:0] rd, input logic we,
                        input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_event: got kind %0d addr/val %h, expected none", kind, a);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", 32'(kind), 32'(e.kind));
            if (kind == e.kind) begin
                if (kind == KReq) begin
                    check("req_addr", a, e.a);
                    check("req_we", 32'(we), 32'(e.we));
                    check("req_wdata", b, e.b);
                end else if (kind == KWb) begin
                    check("wb_rd", 32'(rd), 32'(e.rd));
                    check("wb_value", a, e.a);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            req_prev <= 1'b0;
        end else begin
            if (dmem_req && !req_prev) take(KReq, 5'd0, dmem_we, dmem_addr, dmem_wdata);
            if (regWrite_MEMWB) take(KWb, rd_MEMWB, 1'b0, valueToWB, 32'd0);
            if (misaligned) take(KMis, 5'd0, 1'b0, 32'd0, 32'd0);
            if (busError) take(KBus, 5'd0, 1'b0, 32'd0, 32'd0);
            if (misaligned || busError)
                check("fault_exclusive", 32'(misaligned & busError), 32'd0);
            req_prev <= dmem_req;
        end
    end

    // Presents one op and services the memory until the stage stops stalling.
    task automatic run_op(input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                          input logic m2r, input logic [31:0] res, input logic [31:0] wd,
                          input int ack_at, input logic ack_idle, input logic [31:0] rdata,
                          output int stall_cyc, output int we_cyc, output int acc_cyc);
        logic done;
        done            = 1'b0;
        stall_cyc       = 0;
        we_cyc          = 0;
        acc_cyc         = 0;
        rd_EXMEM        = rd;
        regWrite_EXMEM  = rw;
        memRead_EXMEM   = mr;
        memWrite_EXMEM  = mw;
        memToReg_EXMEM  = m2r;
        result_EXMEM    = res;
        writeData_EXMEM = wd;
        valid_EXMEM     = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            if (dmem_req) begin
                acc_cyc++;
                dmem_ack   = (acc_cyc == ack_at);
                dmem_rdata = (acc_cyc == ack_at) ? rdata : 32'hFFFF_FFFF;
            end else begin
                dmem_ack   = ack_idle;
                dmem_rdata = 32'hCAFE_0000;
            end
            @(negedge clk);
            if (dmem_we) we_cyc++;
            if (stall) stall_cyc++;
            done = !stall;
            @(posedge clk);
            #1;
        end
        if (!done) check("op_completes", 32'd0, 32'd1);
        valid_EXMEM = 1'b0;
        dmem_ack    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int s, w, a;

    initial begin
        reset           = 1'b0;
        dmem_ack        = 1'b0;
        dmem_rdata      = 32'd0;
        rd_EXMEM        = 5'd4;
        regWrite_EXMEM  = 1'b1;
        memRead_EXMEM   = 1'b1;
        memWrite_EXMEM  = 1'b0;
        memToReg_EXMEM  = 1'b1;
        result_EXMEM    = 32'h40;
        writeData_EXMEM = 32'h0;
        valid_EXMEM     = 1'b1;

        // Aligned load held at the inputs while in reset must not stall or request.
        #12;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_rd", 32'(rd_MEMWB), 32'd0);
        check("rst_regwrite", 32'(regWrite_MEMWB), 32'd0);
        check("rst_value", valueToWB, 32'd0);
        check("rst_mis", 32'(misaligned), 32'd0);
        check("rst_berr", 32'(busError), 32'd0);
        valid_EXMEM = 1'b0;
        #10;
        reset = 1'b1;
        idle(2);

        // ALU op, with a stray ack in idle that must be ignored.
        push(KWb, 5'd5, 1'b0, 32'h2A, 32'd0);
        run_op(5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2A, 32'h0, 0, 1'b1, 32'h0, s, w, a);
        check("alu_stall", 32'(s), 32'd0);
        idle(1);

        // Invalid slot: no writeback event expected.
        valid_EXMEM = 1'b0;
        regWrite_EXMEM = 1'b1;
        result_EXMEM = 32'h77;
        idle(2);

        // Load 0x100, ack in the 4th access cycle.
        push(KReq, 5'd0, 1'b0, 32'h100, 32'h0000_1111);
        push(KWb, 5'd7, 1'b0, 32'hDEAD_BEEF, 32'd0);
        run_op(5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0000_1111, 4, 1'b0,
               32'hDEAD_BEEF, s, w, a);
        check("load_stall", 32'(s), 32'd4);
        check("load_access", 32'(a), 32'd4);
        check("load_we", 32'(w), 32'd0);
        idle(1);

        // Store 0x104, ack in the first access cycle.
        push(KReq, 5'd0, 1'b1, 32'h104, 32'h1234_5678);
        run_op(5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 32'h104, 32'h1234_5678, 1, 1'b0, 32'h0, s, w, a);
        check("store_stall", 32'(s), 32'd1);
        check("store_we", 32'(w), 32'd1);
        idle(1);

        // Misaligned load.
        push(KMis, 5'd0, 1'b0, 32'd0, 32'd0);
        run_op(5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 32'h102, 32'h0, 1, 1'b0, 32'h0, s, w, a);
        check("mis_stall", 32'(s), 32'd0);
        check("mis_access", 32'(a), 32'd0);
        idle(1);

        // Timeout with no ack.
        push(KReq, 5'd0, 1'b0, 32'h180, 32'h0);
        push(KBus, 5'd0, 1'b0, 32'd0, 32'd0);
        run_op(5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 32'h180, 32'h0, 0, 1'b0, 32'h0, s, w, a);
        check("tmo_stall", 32'(s), 32'd4);
        check("tmo_access", 32'(a), 32'd4);
        idle(1);

        // Ack coinciding with the timeout cycle completes normally.
        push(KReq, 5'd0, 1'b0, 32'h184, 32'h0);
        push(KWb, 5'd11, 1'b0, 32'h5555_AAAA, 32'd0);
        run_op(5'd11, 1'b1, 1'b1, 1'b0, 1'b1, 32'h184, 32'h0, 4, 1'b0,
               32'h5555_AAAA, s, w, a);
        check("late_ack_access", 32'(a), 32'd4);
        idle(1);

        // Load without memToReg writes back the address.
        push(KReq, 5'd0, 1'b0, 32'h200, 32'h0);
        push(KWb, 5'd12, 1'b0, 32'h200, 32'd0);
        run_op(5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 2, 1'b0, 32'h9999, s, w, a);
        check("addr_wb_stall", 32'(s), 32'd2);

        // Back-to-back store then load: each must start a fresh request.
        push(KReq, 5'd0, 1'b1, 32'h300, 32'hA5A5_A5A5);
        push(KReq, 5'd0, 1'b0, 32'h304, 32'h0);
        push(KWb, 5'd13, 1'b0, 32'h0BAD_F00D, 32'd0);
        run_op(5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h300, 32'hA5A5_A5A5, 1, 1'b0, 32'h0, s, w, a);
        run_op(5'd13, 1'b1, 1'b1, 1'b0, 1'b1, 32'h304, 32'h0, 1, 1'b0,
               32'h0BAD_F00D, s, w, a);
        idle(2);

        // Reset in the 2nd access cycle; a later ack must do nothing.
        push(KReq, 5'd0, 1'b0, 32'h400, 32'h0);
        rd_EXMEM = 5'd3;
        regWrite_EXMEM = 1'b1;
        memRead_EXMEM = 1'b1;
        memWrite_EXMEM = 1'b0;
        memToReg_EXMEM = 1'b1;
        result_EXMEM = 32'h400;
        writeData_EXMEM = 32'h0;
        valid_EXMEM = 1'b1;
        idle(2);
        check("pre_rst_req", 32'(dmem_req), 32'd1);
        reset = 1'b0;
        #1;
        check("arst_req", 32'(dmem_req), 32'd0);
        check("arst_stall", 32'(stall), 32'd0);
        check("arst_addr", dmem_addr, 32'd0);
        check("arst_value", valueToWB, 32'd0);
        check("arst_regwrite", 32'(regWrite_MEMWB), 32'd0);
        valid_EXMEM = 1'b0;
        idle(1);
        reset = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_req", 32'(dmem_req), 32'd0);
            check("post_rst_regwrite", 32'(regWrite_MEMWB), 32'd0);
        end
        dmem_ack = 1'b0;
        idle(3);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
